pwl_eval_ctrl: RTL and testbench

Sequencing controller for the piecewise-linear function approximator (y = A·x + B, Q6.10). It accepts one operand per handshake and finds its segment with a fixed 4-step binary search over a run-time-loadable breakpoint table. It then fetches that segment's {A,B} coefficients and drives one shared multiply-then-add pass with saturation. It replaces the file-loaded breakpoint memory and the combinational segment decoder with a configurable, handshaked unit.

---
 rtl/pwl_eval_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pwl_eval_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_eval_ctrl.sv
// ---------------------------------------------------------------------------
// pwl_eval_ctrl
// Sequencing controller for a piecewise-linear approximator y = A*x + B in
// Q6.10. One operand per handshake: a 4-step binary search over a loadable
// breakpoint table picks the segment, then its {A,B} coefficients feed a
// single multiply-then-add pass with saturation.
//
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   cfg_we/sel/addr/data table write port (sel 0 = breakpoint, 1 = coeff);
//                        writes only commit while idle
//   cfg_err              one-cycle pulse when a write is dropped
//   in_valid/in_ready    operand handshake, x_in in Q6.10
//   out_valid/out_ready  result handshake, y_out in Q6.10, y_ovf = saturated
//   busy                 controller is not idle
// ---------------------------------------------------------------------------
module pwl_eval_ctrl (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [3:0]    cfg_addr,
    input  logic [31:0]   cfg_data,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   x_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   y_out,
    output logic          y_ovf,
    output logic          busy
);

    localparam int unsigned WL   = 16;
    localparam int unsigned WF   = 10;
    localparam int unsigned NSEG = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned CW   = 2 * WL;
    localparam int unsigned PW   = 2 * WL;
    localparam int unsigned SW   = PW - WF + 1;

    localparam logic signed [SW-1:0] S_MAX = SW'(2**(WL-1) - 1);
    localparam logic signed [SW-1:0] S_MIN = SW'(-(2**(WL-1)));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_FETCH  = 3'd2,
        S_MUL    = 3'd3,
        S_ADD    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  r_state;
    logic signed [WL-1:0]    r_x;
    logic        [AW-1:0]    r_lo;
    logic        [AW-1:0]    r_hi;
    logic        [1:0]       r_step;
    logic signed [WL-1:0]    r_a;
    logic signed [WL-1:0]    r_b;
    logic signed [PW-1:0]    r_p;
    logic        [WL-1:0]    r_y;
    logic                    r_ovf;
    logic                    r_out_valid;
    logic                    r_in_ready;
    logic                    r_busy;
    logic                    r_cfg_err;

    logic signed [WL-1:0]    r_bp [NSEG];
    logic        [CW-1:0]    r_cf [NSEG];

    logic        [AW:0]      w_lohi;
    logic        [AW-1:0]    w_mid;
    logic                    w_le;
    logic signed [SW-1:0]    w_sum;
    logic                    w_idle;
    logic                    w_cfg_ok;

    // Midpoint of the current search window; 5-bit sum avoids wrap.
    assign w_lohi = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid  = w_lohi[AW:1];
    // mid < hi throughout the search, so bp[15] is never addressed.
    assign w_le   = (r_x <= r_bp[w_mid]);

    // Product realigned to Q6.10 (arithmetic shift floors) plus B.
    assign w_sum  = SW'(r_p >>> WF) + SW'(r_b);

    assign w_idle   = (r_state == S_IDLE);
    assign w_cfg_ok = cfg_we && w_idle;

    // Table registers; writes commit only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSEG; i++) begin
                r_bp[i] <= '0;
                r_cf[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            if (cfg_sel) begin
                r_cf[cfg_addr] <= cfg_data;
            end else begin
                r_bp[cfg_addr] <= cfg_data[WL-1:0];
            end
        end
    end

    // Dropped-write indicator, one pulse per rejected write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_idle;
        end
    end

    // Sequencing FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_step      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_y         <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x        <= x_in;
                        r_lo       <= '0;
                        r_hi       <= AW'(NSEG - 1);
                        r_step     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_le) begin
                        r_hi <= w_mid;
                    end else begin
                        r_lo <= w_mid + AW'(1);
                    end
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // After four halvings lo == hi and names the segment.
                    r_a     <= r_cf[r_lo][CW-1:WL];
                    r_b     <= r_cf[r_lo][WL-1:0];
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_p     <= PW'(r_a) * PW'(r_x);
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    if (w_sum > S_MAX) begin
                        r_y   <= S_MAX[WL-1:0];
                        r_ovf <= 1'b1;
                    end else if (w_sum < S_MIN) begin
                        r_y   <= S_MIN[WL-1:0];
                        r_ovf <= 1'b1;
                    end else begin
                        r_y   <= w_sum[WL-1:0];
                        r_ovf <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_err   = r_cfg_err;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y_out     = r_y;
    assign y_ovf     = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pwl_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwl_eval_ctrl
// Directed, table-driven bench for pwl_eval_ctrl with hand-computed results,
// plus sequences for backpressure, config guard and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_pwl_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic        cfg_sel;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_out;
    logic        y_ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    pwl_eval_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .y_ovf     (y_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cf_addr;
        logic [31:0] cf_data;
        logic [15:0] x;
        logic [15:0] y;
        logic        ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic write_cfg(input logic sel, input logic [3:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Full transaction: accept, wait for result, drain with out_ready.
    task automatic run_op(input logic [15:0] x, output logic [15:0] y,
                          output logic ovf, output int lat);
        in_valid = 1'b1;
        x_in     = x;
        tick();
        in_valid = 1'b0;
        check("accept_in_ready", 32'(in_ready), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        y   = y_out;
        ovf = y_ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    logic [15:0] y_got;
    logic [15:0] y_hold;
    logic        ovf_got;
    int          lat;

    initial begin
        // Coefficient loads and expected results (bp[i] = (i+1)*0x0192).
        vecs[0] = '{4'd1,  32'h0400_0100, 16'h0300, 16'h0400, 1'b0}; // seg 1, basic
        vecs[1] = '{4'd15, 32'h0000_1234, 16'h7000, 16'h1234, 1'b0}; // catch-all
        vecs[2] = '{4'd0,  32'h0000_0AAA, 16'h0192, 16'h0AAA, 1'b0}; // equality -> seg 0
        vecs[3] = '{4'd1,  32'hFC00_0000, 16'h0300, 16'hFD00, 1'b0}; // negative A
        vecs[4] = '{4'd0,  32'hFFFF_0000, 16'h0001, 16'hFFFF, 1'b0}; // floor
        vecs[5] = '{4'd15, 32'h7FFF_7FFF, 16'h7FFF, 16'h7FFF, 1'b1}; // +sat
        vecs[6] = '{4'd15, 32'h8000_8000, 16'h7FFF, 16'h8000, 1'b1}; // -sat
        vecs[7] = '{4'd2,  32'h0800_FC00, 16'h0400, 16'h0400, 1'b0}; // seg 2, B<0
        vecs[8] = '{4'd0,  32'h0200_0000, 16'hF000, 16'hF800, 1'b0}; // negative x

        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; x_in = '0; out_ready = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y_out", 32'(y_out), 32'd0);
        check("rst_y_ovf", 32'(y_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            write_cfg(1'b0, 4'(i), 32'((i + 1) * 16'h0192));
        end
        check("cfg_err_idle", 32'(cfg_err), 32'd0);

        // Table-driven evaluations.
        for (int i = 0; i < 9; i++) begin
            write_cfg(1'b1, vecs[i].cf_addr, vecs[i].cf_data);
            run_op(vecs[i].x, y_got, ovf_got, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd7);
            check($sformatf("vec%0d_y", i), 32'(y_got), 32'(vecs[i].y));
            check($sformatf("vec%0d_ovf", i), 32'(ovf_got), 32'(vecs[i].ovf));
        end

        // Backpressure: result held while out_ready stays low.
        write_cfg(1'b1, 4'd1, 32'h0400_0100);
        in_valid = 1'b1; x_in = 16'h0300;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd7);
        y_hold = y_out;
        check("bp_y", 32'(y_hold), 32'h0400);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_y", 32'(y_out), 32'(y_hold));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_busy", 32'(busy), 32'd0);
        // Back-to-back: operand waiting is taken on the very next edge.
        in_valid = 1'b1; x_in = 16'h0300;
        tick();
        check("b2b_accept1", 32'(busy), 32'd1);
        wait_valid(lat);
        check("b2b_lat1", 32'(lat), 32'd7);
        check("b2b_y1", 32'(y_out), 32'h0400);
        tick();
        check("b2b_drain1", 32'(in_ready), 32'd1);
        x_in = 16'h7000;
        tick();
        in_valid = 1'b0;
        check("b2b_accept2", 32'(busy), 32'd1);
        wait_valid(lat);
        check("b2b_lat2", 32'(lat), 32'd7);
        check("b2b_y2", 32'(y_out), 32'h8000);
        tick();
        out_ready = 1'b0;

        // Config guard: write during SEARCH is dropped and flagged once.
        in_valid = 1'b1; x_in = 16'h0300;
        tick();
        in_valid = 1'b0;
        tick();
        write_cfg(1'b1, 4'd1, 32'hDEAD_BEEF);
        check("guard_err_pulse", 32'(cfg_err), 32'd1);
        tick();
        check("guard_err_clear", 32'(cfg_err), 32'd0);
        wait_valid(lat);
        check("guard_y", 32'(y_out), 32'h0400);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_op(16'h0300, y_got, ovf_got, lat);
        check("guard_table_kept", 32'(y_got), 32'h0400);

        // Reset during MUL.
        in_valid = 1'b1; x_in = 16'h0300;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_y_out", 32'(y_out), 32'd0);
        check("mrst_cfg_err", 32'(cfg_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        run_op(16'h0300, y_got, ovf_got, lat);
        check("mrst_lat", 32'(lat), 32'd7);
        check("mrst_y_zero_tables", 32'(y_got), 32'd0);
        check("mrst_ovf", 32'(ovf_got), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
